// File: rtl/vx_ti_agent_mc.sv
// Multi-channel TI agent: pairs SFU execute requests with round-robin TI bus
// stamp packets, mirrors accepted stamps to CSR and buffers per-lane commits.
module vx_ti_agent_mc #(
   parameter int unsigned NUM_CHANNELS = 2,
   parameter int unsigned NUM_LANES    = 4,
   parameter int unsigned RSP_DEPTH    = 4,
   parameter int unsigned STAMP_W      = 64,
   parameter int unsigned PID_SW       = 16,
   parameter int unsigned XLEN         = 32,
   parameter int unsigned EXE_W        = 64,
   localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  clear,
   input  logic                                  exe_valid,
   output logic                                  exe_ready,
   input  logic [EXE_W-1:0]                      exe_meta,
   input  logic [NUM_CHANNELS-1:0]               bus_valid,
   output logic [NUM_CHANNELS-1:0]               bus_ready,
   input  logic [NUM_CHANNELS-1:0]               bus_done,
   input  logic [NUM_CHANNELS*NUM_LANES*STAMP_W-1:0] bus_stamps,
   output logic                                  csr_we,
   output logic [CH_W-1:0]                       csr_ch,
   output logic [EXE_W-1:0]                      csr_meta,
   output logic [NUM_LANES*STAMP_W-1:0]          csr_stamps,
   output logic                                  cmt_valid,
   input  logic                                  cmt_ready,
   output logic [EXE_W-1:0]                      cmt_meta,
   output logic [NUM_LANES*XLEN-1:0]             cmt_data,
   output logic                                  cmt_wb
);

   localparam int unsigned PKT_W  = NUM_LANES * STAMP_W;
   localparam int unsigned PIDS_W = NUM_LANES * PID_SW;
   localparam int unsigned AW     = $clog2(RSP_DEPTH);
   localparam int unsigned CW     = AW + 1;

   logic [NUM_CHANNELS-1:0] done_flags;
   logic [CH_W-1:0]         rr_ptr;
   logic [CH_W-1:0]         sel;
   logic                    sel_found;
   logic [PKT_W-1:0]        sel_pkt;
   logic                    all_done;
   logic                    full;
   logic                    fire_bus;
   logic                    fire_done;
   logic                    push;
   logic                    pop;
   logic [PIDS_W-1:0]       push_pids;
   logic                    push_done;

   logic [CW-1:0]           count;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [EXE_W-1:0]        meta_mem [RSP_DEPTH];
   logic [PIDS_W-1:0]       pid_mem  [RSP_DEPTH];
   logic [RSP_DEPTH-1:0]    done_mem;

   // Round-robin pick: first valid, not-yet-done channel starting at rr_ptr
   always_comb begin
      int unsigned idx;
      idx       = 0;
      sel       = '0;
      sel_found = 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         idx = (32'(rr_ptr) + i) % NUM_CHANNELS;
         if (!sel_found && bus_valid[CH_W'(idx)] && !done_flags[CH_W'(idx)]) begin
            sel       = CH_W'(idx);
            sel_found = 1'b1;
         end
      end
   end

   // Mux the selected channel's packet; constant slices keep the select narrow
   always_comb begin
      sel_pkt = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (CH_W'(c) == sel) sel_pkt = bus_stamps[c*PKT_W +: PKT_W];
      end
   end

   assign all_done  = &done_flags;
   assign full      = (count == CW'(RSP_DEPTH));
   assign fire_bus  = !reset && exe_valid && !full && !all_done && sel_found;
   assign fire_done = !reset && exe_valid && !full && all_done;
   assign push      = fire_bus || fire_done;
   assign pop       = cmt_valid && cmt_ready;

   // Handshake and CSR mirror of the accepted packet
   always_comb begin
      exe_ready  = push;
      csr_we     = fire_bus;
      bus_ready  = fire_bus ? (NUM_CHANNELS'(1) << sel) : '0;
      csr_ch     = sel;
      csr_meta   = exe_meta;
      csr_stamps = sel_pkt;
   end

   // Commit payload: lane pids from the packet, or zeros once every channel is drained
   always_comb begin
      push_pids = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         if (fire_bus) push_pids[l*PID_SW +: PID_SW] = sel_pkt[l*STAMP_W +: PID_SW];
      end
      push_done = all_done ? 1'b1 : bus_done[sel];
   end

   // Sticky per-channel done; clear wins over a same-cycle set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_flags <= '0;
         rr_ptr     <= '0;
      end else begin
         if (clear)
            done_flags <= '0;
         else if (fire_bus && bus_done[sel])
            done_flags[sel] <= 1'b1;
         if (fire_bus)
            rr_ptr <= (sel == CH_W'(NUM_CHANNELS - 1)) ? '0 : sel + 1'b1;
      end
   end

   // Commit FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Commit FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         meta_mem[wr_ptr] <= exe_meta;
         pid_mem[wr_ptr]  <= push_pids;
         done_mem[wr_ptr] <= push_done;
      end
   end

   // Commit outputs straight from the FIFO head
   always_comb begin
      cmt_valid = (count != '0);
      cmt_meta  = meta_mem[rd_ptr];
      cmt_wb    = 1'b1;
      cmt_data  = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         cmt_data[l*XLEN +: XLEN] = XLEN'({pid_mem[rd_ptr][l*PID_SW +: PID_SW], ~done_mem[rd_ptr]});
      end
   end

endmodule

// File: tb/tb_vx_ti_agent_mc.sv
// Directed bench for vx_ti_agent_mc: arbitration, sticky done, clear, FIFO full and reset.
module tb_vx_ti_agent_mc;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic          exe_valid;
   logic          exe_ready;
   logic [63:0]   exe_meta;
   logic [1:0]    bus_valid;
   logic [1:0]    bus_ready;
   logic [1:0]    bus_done;
   logic [511:0]  bus_stamps;
   logic          csr_we;
   logic [0:0]    csr_ch;
   logic [63:0]   csr_meta;
   logic [255:0]  csr_stamps;
   logic          cmt_valid;
   logic          cmt_ready;
   logic [63:0]   cmt_meta;
   logic [127:0]  cmt_data;
   logic          cmt_wb;

   int vectors = 0;
   int miscompares = 0;

   vx_ti_agent_mc dut (
      .clk(clk), .reset(reset), .clear(clear),
      .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_meta(exe_meta),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_done(bus_done), .bus_stamps(bus_stamps),
      .csr_we(csr_we), .csr_ch(csr_ch), .csr_meta(csr_meta), .csr_stamps(csr_stamps),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_meta(cmt_meta),
      .cmt_data(cmt_data), .cmt_wb(cmt_wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Channel packet: lane l pid = base+l, upper stamp bits tagged with channel/lane
   function automatic logic [255:0] pkt(input int c, input int base);
      logic [255:0] r;
      for (int l = 0; l < 4; l++) r[l*64 +: 64] = {16'hA500 + 16'(c), 16'h00C0, 16'(l), 16'(base + l)};
      return r;
   endfunction

   // Commit lane l = zext({pid, ~done})
   function automatic logic [127:0] expd(input int base, input bit done);
      logic [127:0] r;
      for (int l = 0; l < 4; l++) r[l*32 +: 32] = 32'({16'(base + l), ~done});
      return r;
   endfunction

   function automatic logic [63:0] m(input int n);
      return 64'hC0DE_0000_0000_0000 | 64'(n);
   endfunction

   initial begin
      reset = 1'b1; clear = 1'b0; exe_valid = 1'b0; exe_meta = '0;
      bus_valid = 2'b00; bus_done = 2'b00; cmt_ready = 1'b0;
      bus_stamps = {pkt(1, 'h20), pkt(0, 'h10)};
      #1;
      chk("rst_cmt_valid", cmt_valid, 0);
      chk("rst_exe_ready", exe_ready, 0);
      chk("rst_csr_we", csr_we, 0);
      exe_valid = 1'b1; bus_valid = 2'b11;
      #1;
      chk("rst_gated_exe_ready", exe_ready, 0);
      chk("rst_gated_bus_ready", bus_ready, 2'b00);
      exe_valid = 1'b0;
      tick(); tick();
      reset = 1'b0; cmt_ready = 1'b1;

      // Back-to-back round robin 0,1,0
      exe_valid = 1'b1; exe_meta = m(1);
      #1;
      chk("rr1_bus_ready", bus_ready, 2'b01);
      chk("rr1_csr_we", csr_we, 1);
      chk("rr1_csr_ch", csr_ch, 0);
      chk("rr1_csr_meta", csr_meta, m(1));
      chk("rr1_csr_stamps", csr_stamps, pkt(0, 'h10));
      chk("rr1_cmt_valid", cmt_valid, 0);
      tick(); exe_meta = m(2);
      #1;
      chk("rr2_cmt_valid", cmt_valid, 1);
      chk("rr2_cmt_meta", cmt_meta, m(1));
      chk("rr2_cmt_data", cmt_data, expd('h10, 0));
      chk("rr2_cmt_wb", cmt_wb, 1);
      chk("rr2_bus_ready", bus_ready, 2'b10);
      chk("rr2_csr_ch", csr_ch, 1);
      tick(); exe_meta = m(3);
      #1;
      chk("rr3_cmt_meta", cmt_meta, m(2));
      chk("rr3_cmt_data", cmt_data, expd('h20, 0));
      chk("rr3_bus_ready", bus_ready, 2'b01);
      tick(); exe_valid = 1'b0;
      #1;
      chk("rr4_cmt_meta", cmt_meta, m(3));
      chk("rr4_cmt_data", cmt_data, expd('h10, 0));
      tick();
      chk("rr_drained", cmt_valid, 0);

      // rr_ptr=1 but only ch0 valid
      bus_valid = 2'b01; exe_valid = 1'b1; exe_meta = m(4);
      #1;
      chk("wrap_bus_ready", bus_ready, 2'b01);
      chk("wrap_csr_ch", csr_ch, 0);
      tick(); bus_valid = 2'b11; exe_meta = m(5);
      #1;
      chk("wrap_next_ch1", bus_ready, 2'b10);
      chk("wrap_cmt_meta", cmt_meta, m(4));
      tick(); exe_valid = 1'b0;
      #1;
      chk("wrap_cmt_meta2", cmt_meta, m(5));
      tick();

      // ch0 done packet with pid 5
      bus_stamps[255:0] = pkt(0, 5);
      bus_valid = 2'b01; bus_done = 2'b01; exe_valid = 1'b1; exe_meta = m(6);
      #1;
      chk("done0_bus_ready", bus_ready, 2'b01);
      tick(); exe_valid = 1'b0; bus_done = 2'b00;
      #1;
      chk("done0_lane0", cmt_data[31:0], 32'h0000_000A);
      chk("done0_cmt_data", cmt_data, expd(5, 1));
      tick();
      exe_valid = 1'b1; exe_meta = m(7); bus_valid = 2'b01;
      #1;
      chk("ch0_ignored_exe_ready", exe_ready, 0);
      chk("ch0_ignored_bus_ready", bus_ready, 2'b00);
      chk("ch0_ignored_csr_we", csr_we, 0);
      bus_valid = 2'b11; bus_done = 2'b10;
      #1;
      chk("done1_bus_ready", bus_ready, 2'b10);
      tick(); exe_valid = 1'b0; bus_done = 2'b00;
      #1;
      chk("done1_cmt_meta", cmt_meta, m(7));
      chk("done1_cmt_data", cmt_data, expd('h20, 1));
      tick();

      // Both channels done: synthetic done commit
      exe_valid = 1'b1; exe_meta = m(8);
      #1;
      chk("alldone_exe_ready", exe_ready, 1);
      chk("alldone_bus_ready", bus_ready, 2'b00);
      chk("alldone_csr_we", csr_we, 0);
      tick(); exe_valid = 1'b0;
      #1;
      chk("alldone_cmt_meta", cmt_meta, m(8));
      chk("alldone_cmt_data", cmt_data, 128'h0);
      clear = 1'b1;
      tick(); clear = 1'b0; exe_valid = 1'b1; exe_meta = m(9);
      #1;
      chk("clear_ch0_again", bus_ready, 2'b01);
      tick(); exe_valid = 1'b0;
      #1;
      chk("clear_cmt_data", cmt_data, expd(5, 0));
      tick();

      // Clear beats a same-cycle done set (rr_ptr=1 -> ch1)
      clear = 1'b1; bus_done = 2'b10; exe_valid = 1'b1; exe_meta = m(20);
      #1;
      chk("clrset_bus_ready", bus_ready, 2'b10);
      tick(); clear = 1'b0; bus_done = 2'b00; bus_valid = 2'b10; exe_meta = m(21);
      #1;
      chk("clrset_flag_clear", bus_ready, 2'b10);
      chk("clrset_cmt_data", cmt_data, expd('h20, 1));
      tick(); exe_valid = 1'b0; bus_valid = 2'b11;
      #1;
      chk("clrset_cmt_meta", cmt_meta, m(21));
      tick();

      // Fill the FIFO with commits stalled
      cmt_ready = 1'b0; exe_valid = 1'b1;
      for (int k = 10; k < 14; k++) begin
         exe_meta = m(k);
         tick();
      end
      exe_meta = m(14);
      #1;
      chk("full_exe_ready", exe_ready, 0);
      chk("full_bus_ready", bus_ready, 2'b00);
      chk("full_cmt_meta", cmt_meta, m(10));
      tick();
      chk("full_hold_meta", cmt_meta, m(10));
      chk("full_hold_ready", exe_ready, 0);
      cmt_ready = 1'b1;
      #1;
      chk("full_pop_no_push", exe_ready, 0);
      tick(); cmt_ready = 1'b0;
      #1;
      chk("after_pop_exe_ready", exe_ready, 1);
      chk("after_pop_cmt_meta", cmt_meta, m(11));
      tick(); exe_valid = 1'b0; cmt_ready = 1'b1;
      for (int k = 11; k < 15; k++) begin
         chk("drain_valid", cmt_valid, 1);
         chk("drain_meta", cmt_meta, m(k));
         if (k == 14) chk("drain_last_data", cmt_data, expd(5, 0));
         tick();
      end
      chk("drain_empty", cmt_valid, 0);

      // Reset with two entries buffered and ch0 flagged done
      cmt_ready = 1'b0; exe_valid = 1'b1; exe_meta = m(15);
      tick(); exe_meta = m(16); bus_done = 2'b01;
      #1;
      chk("pre_rst_bus_ready", bus_ready, 2'b01);
      tick(); exe_valid = 1'b0; bus_done = 2'b00;
      #1;
      chk("pre_rst_cmt_valid", cmt_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_cmt_valid", cmt_valid, 0);
      tick(); reset = 1'b0; cmt_ready = 1'b1; bus_valid = 2'b01; exe_valid = 1'b1; exe_meta = m(17);
      #1;
      chk("post_rst_flag_clear", bus_ready, 2'b01);
      chk("post_rst_cmt_valid", cmt_valid, 0);
      exe_valid = 1'b0;
      tick();
      chk("post_rst_no_stale", cmt_valid, 0);
      tick();
      chk("post_rst_no_stale2", cmt_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
